// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles never reach here in normal operation; blank them.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle, BUS_WIDTH steps.
// done is high for the single DONE cycle, while bcd holds the finished result.
module bin2bcd_serial
    import seg7_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BUS_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BUS_WIDTH + BCD_W;
    localparam int CNT_W = $clog2(BUS_WIDTH + 1);

    conv_state_t       state_r;
    logic [SR_W-1:0]   shift_r;
    logic [SR_W-1:0]   adj_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;

    // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
    always_comb begin
        adj_s = shift_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_r[BUS_WIDTH + d*4 +: 4] >= 4'd5) begin
                adj_s[BUS_WIDTH + d*4 +: 4] = shift_r[BUS_WIDTH + d*4 +: 4] + 4'd3;
            end else begin
                adj_s[BUS_WIDTH + d*4 +: 4] = shift_r[BUS_WIDTH + d*4 +: 4];
            end
        end
    end

    // Conversion FSM; busy and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            shift_r <= {SR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_r <= {{BCD_W{1'b0}}, bin};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_CONVERT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                ST_CONVERT: begin
                    shift_r <= adj_s << 1'b1;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    busy_r  <= 1'b1;
                    if (cnt_r == CNT_W'(BUS_WIDTH - 1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_CONVERT;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = shift_r[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg7_display.sv
// Binary-to-decimal multiplexed common-anode display driver.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter int SCAN_DIV  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  value,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  busy
);

    localparam int BCD_W = DIGITS * 4;
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BUS_WIDTH-1:0] last_r;
    logic [BCD_W-1:0]     bcd_disp_r;
    logic [BCD_W-1:0]     bcd_s;
    logic                 start_s;
    logic                 conv_busy_s;
    logic                 conv_done_s;
    logic [PW-1:0]        presc_r;
    logic [IW-1:0]        idx_r;
    logic [3:0]           nib_s;
    logic                 blank_s;
    logic [DIGITS-1:0]    lz_s;
    logic [DIGITS-1:0]    an_s;
    logic [6:0]           seg_s;
    logic [6:0]           seg_r;
    logic [DIGITS-1:0]    an_r;

    // Only accept a new value while the converter is idle; later changes wait for the compare.
    assign start_s = (value != last_r) && !conv_busy_s;

    bin2bcd_serial #(
        .BUS_WIDTH (BUS_WIDTH),
        .DIGITS    (DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .bin   (value),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (bcd_s)
    );

    // Accepted value and atomically updated display digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r     <= {BUS_WIDTH{1'b0}};
            bcd_disp_r <= {BCD_W{1'b0}};
        end else begin
            if (start_s) begin
                last_r <= value;
            end
            if (conv_done_s) begin
                bcd_disp_r <= bcd_s;
            end
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else if (presc_r == PW'(SCAN_DIV - 1)) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= (idx_r == IW'(DIGITS - 1)) ? {IW{1'b0}} : idx_r + IW'(1);
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic zero_above_s;

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        lz_s         = {DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above_s = zero_above_s && (bcd_disp_r[i*4 +: 4] == 4'd0);
            lz_s[i]      = zero_above_s;
        end
    end
`else
    assign lz_s = {DIGITS{1'b0}};
`endif

    // Select the active digit's nibble, blank flag and anode pattern.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
        an_s    = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            nib_s   = (idx_r == IW'(i)) ? bcd_disp_r[i*4 +: 4] : nib_s;
            blank_s = (idx_r == IW'(i)) ? lz_s[i] : blank_s;
            an_s[i] = (idx_r == IW'(i)) ? 1'b0 : 1'b1;
        end
        seg_s = blank_s ? SEG_BLANK : seg_encode(nib_s);
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r <= SEG_BLANK;
            an_r  <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

    assign seg  = seg_r;
    assign an   = an_r;
    assign busy = conv_busy_s;

endmodule

// File: tb/tb_seg7_display.sv
// Self-checking bench for seg7_display: vector table, hand sequences, random values.
module tb_seg7_display;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int SD = 16;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] CODES [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] value = '0;
    logic [W-1:0] value2 = '0;
    logic [6:0]   seg, seg2;
    logic [D-1:0] an, an2;
    logic         busy, busy2;

    int total = 0;
    int bad   = 0;

    seg7_display #(.BUS_WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .value(value), .seg(seg), .an(an), .busy(busy));

    seg7_display #(.BUS_WIDTH(W), .DIGITS(D), .SCAN_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .value(value2), .seg(seg2), .an(an2), .busy(busy2));

    always #5 clk = ~clk;

    typedef struct {
        int                 v;
        logic [2:0][6:0]    e;
        logic [2:0][6:0]    ez;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digit i of v, blanked if it is a leading zero.
    function automatic logic [6:0] ref_digit(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
`ifdef SEG7_LZ_BLANK_EN
        if (i > 0 && v < p) return SB;
`endif
        return CODES[(v / p) % 10];
    endfunction

    task automatic busy_measure(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    // One full refresh period: every sample one-hot-low, seg matches, SD cycles per digit.
    task automatic scan_check(input logic [2:0][6:0] exp, input string tag);
        int cnt [3];
        int d;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < D*SD; c++) begin
            @(negedge clk);
            case (an)
                3'b110:  d = 0;
                3'b101:  d = 1;
                3'b011:  d = 2;
                default: d = -1;
            endcase
            if (d < 0) begin
                chk({tag, "_an_onehot"}, int'(an), 6);
            end else begin
                cnt[d]++;
                chk({tag, "_seg"}, int'(seg), int'(exp[d]));
            end
        end
        for (int i = 0; i < 3; i++) chk({tag, "_dwell"}, cnt[i], SD);
    endtask

    function automatic logic [2:0] next_an(input logic [2:0] a);
        case (a)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    vec_t tbl [8];

    initial begin
        int n, prev, rises, highs, first_fall, second_rise, run, first;
        logic pb;
        logic [2:0] pa;
        logic [2:0][6:0] exp;

        tbl[0] = '{0,   {S0, S0, S0}, {SB, SB, S0}};
        tbl[1] = '{7,   {S0, S0, S7}, {SB, SB, S7}};
        tbl[2] = '{42,  {S0, S4, S2}, {SB, S4, S2}};
        tbl[3] = '{100, {S1, S0, S0}, {S1, S0, S0}};
        tbl[4] = '{255, {S2, S5, S5}, {S2, S5, S5}};
        tbl[5] = '{9,   {S0, S0, S9}, {SB, SB, S9}};
        tbl[6] = '{10,  {S0, S1, S0}, {SB, S1, S0}};
        tbl[7] = '{99,  {S0, S9, S9}, {SB, S9, S9}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_seg", int'(seg), int'(SB));
        chk("rst_an", int'(an), 6);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_seg", int'(seg), int'(S0));
        chk("post_rst_an", int'(an), 6);

        // Table vectors
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            value = W'(tbl[i].v);
            busy_measure(n);
            chk("busy_len", n, (tbl[i].v != prev) ? W + 1 : 0);
`ifdef SEG7_LZ_BLANK_EN
            exp = tbl[i].ez;
`else
            exp = tbl[i].e;
`endif
            scan_check(exp, "tbl");
            prev = tbl[i].v;
        end

        // 100 then 42 two cycles into the conversion
        value = W'(100);
        rises = 0; highs = 0; first_fall = -1; second_rise = -1; pb = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) highs++;
            if (busy && !pb) begin
                rises++;
                if (rises == 2) second_rise = k;
            end
            if (!busy && pb && first_fall < 0) first_fall = k;
            pb = busy;
            if (k == 2) value = W'(42);
        end
        chk("b2b_rises", rises, 2);
        chk("b2b_highs", highs, 2 * (W + 1));
        chk("b2b_gap", second_rise - first_fall, 1);
        chk("b2b_busy_end", int'(busy), 0);
        for (int i = 0; i < 3; i++) exp[i] = ref_digit(42, i);
        scan_check(exp, "b2b");

        // Reset mid-conversion of 200
        value = W'(200);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_seg", int'(seg), int'(SB));
        chk("midrst_an", int'(an), 6);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_busy", int'(busy), 1);
        chk("restart_seg", int'(seg), int'(S0));
        n = 1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (busy) n++;
            if (k == W + 1) chk("restart_busy_drop", int'(busy), 0);
        end
        chk("restart_busy_len", n, W + 1);
        for (int i = 0; i < 3; i++) exp[i] = ref_digit(200, i);
        scan_check(exp, "midrst");

        // Random values against the arithmetic model
        prev = 200;
        for (int r = 0; r < 6; r++) begin
            int v;
            v = int'($urandom_range(1, 255));
            if (v == prev) v = (v % 255) + 1;
            value = W'(v);
            busy_measure(n);
            chk("rnd_busy_len", n, W + 1);
            for (int i = 0; i < 3; i++) exp[i] = ref_digit(v, i);
            scan_check(exp, "rnd");
            prev = v;
        end

        // SCAN_DIV = 2 instance: strict rotation, every dwell exactly 2 cycles
        @(negedge clk);
        pa = an2; run = 1; first = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (an2 == pa) begin
                run++;
            end else begin
                chk("div2_order", int'(an2), int'(next_an(pa)));
                if (first == 0) chk("div2_dwell", run, 2);
                first = 0;
                run = 1;
                pa = an2;
            end
        end
        chk("div2_idle_busy", int'(busy2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
